// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   SHA-256 message schedule. Captures a 512-bit block into W[0..15] and
//   expands W[16..63] in place, one word per cycle while msa_en is high.
//   The compression stage reads the schedule through an indexed port.
//
// Ports
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   load_block  1-cycle strobe: capture block_in into W[0..15], restart at 16
//   block_in    512-bit message block, word 0 = [511:480], word 15 = [31:0]
//   msa_en      expansion enable (level), honoured only while expanding
//   rd_addr     schedule index to read
//   rd_data     W[rd_addr] (registered, 1-cycle latency by default)
//   sched_busy  expansion in progress
//   sched_done  W[16..63] valid; held until the next load
//
// Build option
//   MSA_RD_BYPASS_EN  when defined, rd_data is combinational from the array
//                     and the RD_RESET_VAL output register is not built.
module sha256_msg_sched #(
  parameter logic [31:0] RD_RESET_VAL = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_block,
  input  logic [511:0] block_in,
  input  logic         msa_en,
  input  logic [5:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         sched_busy,
  output logic         sched_done
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic        wr_en;
  logic [31:0] w [64];
  logic [31:0] w_next;
  logic [5:0]  i6;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Taps wrap in 6 bits; only meaningful for idx 16..63, where no wrap occurs.
  assign i6     = idx_q[5:0];
  assign w_next = sig1(w[i6 - 6'd2]) + w[i6 - 6'd7] +
                  sig0(w[i6 - 6'd15]) + w[i6 - 6'd16];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      idx_q   <= 7'd16;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Load has priority over an expansion step in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    if (load_block) begin
      state_d = EXPAND;
      idx_d   = 7'd16;
    end else if (state_q == EXPAND && msa_en) begin
      wr_en = 1'b1;
      idx_d = idx_q + 7'd1;          // 63 -> 64, then frozen by DONE
      if (idx_q == 7'd63) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 64; i++) w[i] <= '0;
    end else if (load_block) begin
      for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
    end else if (wr_en) begin
      w[i6] <= w_next;
    end
  end

`ifdef MSA_RD_BYPASS_EN
  assign rd_data = w[rd_addr];
`else
  // Registered read samples the pre-edge array, so a same-edge write is
  // seen only on the following read.
  logic [31:0] rd_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rd_q <= RD_RESET_VAL;
    else        rd_q <= w[rd_addr];
  end
  assign rd_data = rd_q;
`endif

  assign sched_busy = (state_q == EXPAND);
  assign sched_done = (state_q == DONE);

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         load_block;
  logic [511:0] block_in;
  logic         msa_en;
  logic [5:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         sched_busy;
  logic         sched_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb [$];
  logic [31:0] mw [64];
  logic [511:0] abc_blk, rnd_blk, c_blk;

  always #5 clk = ~clk;

  sha256_msg_sched #(.RD_RESET_VAL(32'h0000_0000)) dut (
    .clk(clk), .n_rst(n_rst), .load_block(load_block), .block_in(block_in),
    .msa_en(msa_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sched_busy(sched_busy), .sched_done(sched_done)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule from FIPS 180-4.
  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      mw[t] = (rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10)) +
              mw[t-7] +
              (rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3)) +
              mw[t-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd_addr = a;
    sb.push_back(exp);
`ifdef MSA_RD_BYPASS_EN
    #1;
`else
    @(posedge clk); #1;
`endif
    chk($sformatf("%s[%0d]", tag, a), rd_data, sb.pop_front());
  endtask

  task automatic rd_all(input string tag);
    for (int t = 0; t < 64; t++) rd_chk(t[5:0], mw[t], tag);
  endtask

  task automatic do_load(input logic [511:0] b);
    @(negedge clk);
    block_in = b; load_block = 1'b1;
    @(negedge clk);
    load_block = 1'b0;
  endtask

  // Hold msa_en high from the cycle after a load; returns edges until done.
  task automatic run_to_done(output int cnt);
    cnt = 0;
    msa_en = 1'b1;
    while (!sched_done && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    msa_en = 1'b0;
  endtask

  int cnt, lows, en_cnt;
  logic [31:0] w30_prev;

  initial begin
    abc_blk = '0;
    abc_blk[511:480] = 32'h6162_6380;
    abc_blk[31:0]    = 32'h0000_0018;
    for (int i = 0; i < 16; i++) begin
      rnd_blk[511-32*i -: 32] = $urandom;
      c_blk[511-32*i -: 32]   = $urandom;
    end
    n_rst = 1'b0; load_block = 1'b0; block_in = '0; msa_en = 1'b0; rd_addr = '0;
    #23;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_busy", {31'b0, sched_busy}, 32'h0);
    chk("rst_done", {31'b0, sched_done}, 32'h0);
    @(negedge clk); n_rst = 1'b1;

    // Mid-cycle asynchronous reset during expansion
    do_load(abc_blk);
    chk("load_busy", {31'b0, sched_busy}, 32'h1);
    msa_en = 1'b1;
    rd_addr = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_rd", rd_data, 32'h6162_6380);
    #2; n_rst = 1'b0; #1;
    chk("async_rd_data", rd_data, 32'h0);
    chk("async_busy", {31'b0, sched_busy}, 32'h0);
    chk("async_done", {31'b0, sched_done}, 32'h0);
    @(negedge clk); n_rst = 1'b1;

    // msa_en with no load: nothing happens
    msa_en = 1'b1;
    repeat (5) @(negedge clk);
    msa_en = 1'b0;
    chk("noload_busy", {31'b0, sched_busy}, 32'h0);
    chk("noload_done", {31'b0, sched_done}, 32'h0);
    rd_chk(6'd16, 32'h0, "noload_w");

    // Golden "abc" block
    build_model(abc_blk);
    do_load(abc_blk);
    run_to_done(cnt);
    chk("gold_done_edges", cnt, 48);
    chk("gold_busy", {31'b0, sched_busy}, 32'h0);
    rd_chk(6'd16, 32'h6162_6380, "gold_w16");
    rd_chk(6'd17, 32'h000F_0000, "gold_w17");
    rd_chk(6'd63, 32'h12B1_EDEB, "gold_w63");
    rd_all("gold");

    // Read latency at address 17
    @(negedge clk); rd_addr = 6'd16;
    @(negedge clk); rd_addr = 6'd17; #1;
`ifdef MSA_RD_BYPASS_EN
    chk("lat_same_cycle", rd_data, 32'h000F_0000);
`else
    chk("lat_same_cycle", rd_data, 32'h6162_6380);
    @(posedge clk); #1;
    chk("lat_next_cycle", rd_data, 32'h000F_0000);
`endif

    // DONE ignores msa_en
    @(negedge clk); msa_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("done_hold", {31'b0, sched_done}, 32'h1);
      chk("done_busy", {31'b0, sched_busy}, 32'h0);
    end
    msa_en = 1'b0;
    rd_all("done_arr");

    // Collision at idx 30: load wins, W[30] untouched
    w30_prev = mw[30];
    do_load(rnd_blk);
    chk("reload_done_drop", {31'b0, sched_done}, 32'h0);
    msa_en = 1'b1;
    repeat (14) @(negedge clk);           // idx now 30
    block_in = c_blk; load_block = 1'b1;  // msa_en still high
    @(negedge clk);
    load_block = 1'b0; msa_en = 1'b0;
    rd_chk(6'd30, w30_prev, "coll_w30");
    build_model(c_blk);
    run_to_done(cnt);
    chk("coll_done_edges", cnt, 48);
    rd_all("coll");

    // Paused expansion with pattern 1,0,0,1
    build_model(abc_blk);
    do_load(abc_blk);
    cnt = 0; lows = 0; en_cnt = 0;
    while (!sched_done && cnt < 400) begin
      msa_en = (cnt % 4 == 0 || cnt % 4 == 3);
      if (!msa_en) lows++;
      @(posedge clk); #1; cnt++;
      if (!sched_done) @(negedge clk);
    end
    msa_en = 1'b0;
    chk("pause_lows", lows, 48);
    chk("pause_done_edges", cnt, 48 + lows);
    rd_all("pause");

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

SHA-256 message schedule unit for the bitcoin miner core. It sits directly downstream of the core control unit and is driven by that unit's `msa_en` phase. It captures a 512-bit block and expands it in place into the 64-word schedule W[0..63], at one new word per enabled cycle. The compression stage then reads the schedule through an indexed read port.

## Interface
- `RD_RESET_VAL`, default 32'h0000_0000: value driven on `rd_data` after reset.
- `clk` input 1: system clock; all state updates on the rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `load_block` input 1: single-cycle strobe that captures `block_in` into W[0..15].
- `block_in` input 512: message block. Word 0 is [511:480] and word 15 is [31:0].
- `msa_en` input 1: expansion enable from the control unit (level).
- `rd_addr` input 6: schedule index requested by the compression stage.
- `rd_data` output 32: W[`rd_addr`].
- `sched_busy` output 1: expansion in progress (index 16..63 and not yet done).
- `sched_done` output 1: all of W[16..63] are valid; held until the next load.

## Operation
- Storage is a 64×32 register array plus a 7-bit write index `idx`.
- States:
  - EMPTY: after reset.
  - EXPAND: after a load.
  - DONE: after W[63] is written.
- `load_block`, in any state:
  - W[i] ← `block_in` word i, for i = 0..15.
  - `idx` ← 16; state ← EXPAND.
  - W[16..63] are not cleared.
- EXPAND with `msa_en` = 1: each cycle, W[idx] is written with the sum below, then `idx` increments.
  - Sum: σ1(W[idx−2]) + W[idx−7] + σ0(W[idx−15]) + W[idx−16], mod 2^32, carries discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- EXPAND with `msa_en` = 0: hold. `idx` and the array are unchanged, so expansion can be paused and resumed losslessly.
- End of expansion: when the write to W[63] occurs, state → DONE on that edge and `idx` saturates at 64.
- `msa_en` in EMPTY or DONE is ignored; no writes occur.
- `load_block` and `msa_en` in the same cycle: the load wins and no expansion write happens that cycle.
- Reads of a word not yet computed return the stored (stale) contents. There is no error flag; the control unit guarantees ordering because COMP follows a 48-cycle MSA phase.
- Outputs:
  - `sched_busy` = (state == EXPAND).
  - `sched_done` = (state == DONE).

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state EMPTY, `idx` = 16, array cleared to 0.
  - `rd_data` = `RD_RESET_VAL`, `sched_busy` = 0, `sched_done` = 0.
- Load: W[0..15] are readable on the first edge after the `load_block` edge; `sched_busy` = 1 that same cycle.
- Expansion takes exactly 48 enabled cycles. With `msa_en` held high from the cycle after the load, `sched_done` rises 48 cycles after the load edge, matching the control unit's rollover value of 48.
- Read latency (default): `rd_data` is registered. It presents W[`rd_addr`] one cycle after the address is applied.
- Same-edge read/write: a read of the index being written in the same cycle returns the old value. The new value is visible on the following read.
- Reset mid-expansion: the cycle is abandoned immediately and the state returns to EMPTY. A fresh `load_block` is required.
- Reload during EXPAND or DONE: the schedule restarts at `idx` 16 on the next edge and `sched_done` drops on that edge.

## Configuration
- `MSA_RD_BYPASS_EN`:
  - Defined: `rd_data` is combinational from the array, so W[`rd_addr`] is valid in the same cycle. The `RD_RESET_VAL` output register is not instantiated; `rd_data` reads array contents, which are 0 after reset.
  - Undefined (default): the registered read port with 1-cycle latency described above.

## Test plan
- Reset checks:
  - Assert `n_rst` = 0 mid-cycle → `rd_data` = 0, `sched_busy` = 0, `sched_done` = 0 immediately.
  - Pulse `msa_en` with no load → no state change.
- Golden block: load the padded "abc" block (word0 = 0x61626380, words 1–14 = 0, word15 = 0x00000018), then hold `msa_en` for 48 cycles.
  - W[16] = 0x61626380.
  - W[17] = 0x000F0000.
  - W[63] = 0x12B1EDEB.
  - `sched_done` rises on the 48th enabled edge.
- Pause: the same block with `msa_en` toggled 1,0,0,1… → identical W[16..63] to the golden run, and `sched_done` delayed by exactly the number of low cycles.
- Collision: `load_block` and `msa_en` high in the same cycle during EXPAND at `idx` = 30 → `idx` = 16 next cycle and W[30] is not written by that cycle.
- Done state: after DONE, 10 extra `msa_en` cycles → the array is unchanged, `sched_done` stays 1 and `sched_busy` stays 0.
- Read latency, `rd_addr` = 17 after DONE:
  - Default build: `rd_data` = 0x000F0000 one cycle later.
  - With `MSA_RD_BYPASS_EN`: the same value in the same cycle.
